// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// One radix-2 step per cycle: shift-add multiply and restoring divide on operand
// magnitudes, followed by a single sign-fix cycle. Divide corner cases can
// optionally complete in the accept cycle. Result is held until consumed.
module execute_muldiv #(
    parameter int XLEN         = 32,
    parameter int TAG_W        = 5,
    parameter int FAST_SPECIAL = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIX,
        S_DONE
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    op_e                 op_q;
    logic                neg_q;      // negate product / quotient in FIX
    logic                neg_rem_q;  // negate remainder in FIX (dividend sign)
    logic [XLEN-1:0]     b_q;        // |rs2|
    logic [2*XLEN-1:0]   prod_q;     // mul: {acc, multiplier}; div: {remainder, dividend/quotient}
    logic [XLEN-1:0]     result_q;
    logic [TAG_W-1:0]    tag_q;

    op_e                 op_in;
    logic                sign_a;
    logic                sign_b;
    logic                b_zero;
    logic                overflow;
    logic                special;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic [XLEN-1:0]     fast_res;

    // Decode the incoming request: operand signs, magnitudes and divide corner cases.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        op_in  = op_e'(op_i);
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (op_in)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                sign_a = rs1_i[XLEN-1];
                sign_b = rs2_i[XLEN-1];
            end
            OP_MULHSU: sign_a = rs1_i[XLEN-1];
            default: ;
        endcase
        // Magnitude of INT_MIN is 2^(XLEN-1), which still fits as an unsigned XLEN value.
        a_mag    = sign_a ? -rs1_i : rs1_i;
        b_mag    = sign_b ? -rs2_i : rs2_i;
        b_zero   = (rs2_i == '0);
        overflow = ((op_in == OP_DIV) || (op_in == OP_REM)) && (rs1_i == INT_MIN) && (rs2_i == '1);
        special  = op_i[2] && (b_zero || overflow);
        if (b_zero) begin
            fast_res = op_i[1] ? rs1_i : '1;
        end else begin
            fast_res = op_i[1] ? '0 : rs1_i;
        end
    end

    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_diff;
    logic                div_ge;
    logic [2*XLEN-1:0]   step_next;

    // One radix-2 iteration of either the shift-add multiply or the restoring divide.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : '0);
        div_shift = prod_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = ~div_diff[XLEN];
        if (op_q[2]) begin
            step_next = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                         prod_q[XLEN-2:0], div_ge};
        end else begin
            step_next = {mul_sum, prod_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quot_fix;
    logic [XLEN-1:0]     rem_fix;
    logic [XLEN-1:0]     fix_res;

    // Sign correction and result selection applied in the FIX cycle.
    always_comb begin
        prod_fix = neg_q ? -prod_q : prod_q;
        quot_fix = neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
        rem_fix  = neg_rem_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res = quot_fix;
            default:                      fix_res = rem_fix;
        endcase
    end

    // Control FSM with operand, iteration and result registers.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            // NOTE: operand/datapath registers are left unreset; they are always loaded on accept before use.
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            tag_q    <= '0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        op_q      <= op_in;
                        b_q       <= b_mag;
                        prod_q    <= {{XLEN{1'b0}}, a_mag};
                        // Divide by zero must yield all ones, so never negate that quotient.
                        neg_q     <= (sign_a ^ sign_b) && !(op_i[2] && b_zero);
                        neg_rem_q <= sign_a;
                        tag_q     <= tag_i;
                        cnt_q     <= '0;
                        if ((FAST_SPECIAL != 0) && special) begin
                            result_q <= fast_res;
                            state_q  <= S_DONE;
                        end else begin
                            state_q <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    prod_q <= step_next;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q <= fix_res;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    if (ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_o  = (state_q == S_IDLE) && !flush_i;
    assign valid_o  = (state_q == S_DONE);
    assign busy_o   = (state_q != S_IDLE);
    assign result_o = result_q;
    assign tag_o    = tag_q;

endmodule
